cpu_run_ctrl: RTL
=================

# cpu_run_ctrl

Synthesizable run controller that drives the CPU's reset and clock-enable and decides when a simulation or board run is over. It replaces the fixed-time "hold reset, run N ns" stimulus with a parametrised sequencer: configurable reset pulse length, cycle-count timeout, self-loop (halt) detection on the PC, external abort, and a frozen cycle count for inspection. It sits between the top-level clock/reset and the `mips` core, and is instantiated in both the bench and the board top.

## Interface
- `RST_CYCLES`, 4: cycles `cpu_reset` is held high in RESET (≥1).
- `MAX_CYCLES`, 2000: RUN-cycle budget. 0 disables the timeout.
- `LOOP_LIMIT`, 8: consecutive equal-PC samples that declare halt. 0 disables loop detection.
- `PC_W`, 32: PC width.
- `CNT_W`, 32: cycle counter width.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- `start`  in  1  run request, sampled in IDLE and DONE only.
- `abort`  in  1  stop request, sampled in RESET and RUN only.
- `pc`  in  PC_W  current PC of the core.
- `cpu_reset`  out  1  synchronous active-high reset to the core.
- `cpu_en`  out  1  core clock-enable.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `done_cause`  out  2  0 none, 1 timeout, 2 loop, 3 abort.
- `cycle_cnt`  out  CNT_W  RUN cycles executed.

## Operation
- States: IDLE, RESET, RUN, DONE. `reset` low → IDLE from any state, including mid-run.
- Output decode (Moore, from the state register only):
  - IDLE: `cpu_reset`=1, `cpu_en`=0.
  - RESET: `cpu_reset`=1, `cpu_en`=0.
  - RUN: `cpu_reset`=0, `cpu_en`=1, `running`=1.
  - DONE: `cpu_reset`=0, `cpu_en`=0, `done`=1. The core state is held for inspection.
- Reset values: state IDLE, `cpu_reset`=1, `cpu_en`=0, `running`=0, `done`=0, `done_cause`=0, `cycle_cnt`=0. Internal `rst_cnt`, `same_cnt` and `pc_prev_vld` are 0.
- IDLE --`start`--> RESET: clear `cycle_cnt`, `done_cause`, `same_cnt`, `pc_prev_vld`; load `rst_cnt`.
- DONE --`start`--> RESET: same clearing.
- RESET → RUN after exactly RST_CYCLES edges. `abort` in RESET → DONE, cause 3, `cycle_cnt`=0.
- RUN, at every edge:
  - `cycle_cnt`+1. It saturates at all-ones when the timeout is disabled.
  - `pc_prev`←`pc`, `pc_prev_vld`←1.
  - `same_cnt` ← (`pc_prev_vld` and `pc`==`pc_prev`) ? `same_cnt`+1 : 0.
- RUN exit conditions, evaluated on the same edge with priority abort > loop > timeout:
  - `abort` → DONE, cause 3.
  - Next `same_cnt`==LOOP_LIMIT → DONE, cause 2.
  - Next `cycle_cnt`==MAX_CYCLES → DONE, cause 1.
- The `cycle_cnt` increment also occurs on the exit edge. `cycle_cnt` and `done_cause` are frozen in DONE.
- `start` in RESET/RUN is ignored. `abort` in IDLE/DONE is ignored.

## Timing
- `start` sampled high at edge T: state=RESET after T; `cpu_en` rises after edge T+RST_CYCLES.
- RUN lasts exactly `cycle_cnt` cycles. On timeout, `done` rises after the edge where `cycle_cnt` becomes MAX_CYCLES.
- Exit latency: `done` is high one cycle after the RUN cycle in which the condition is sampled. `cpu_en` falls on the same edge.
- No combinational input-to-output path.
- Asynchronous `reset` takes effect without a clock edge. Release is synchronous to the next edge.

## Test plan
- RST_CYCLES=4, MAX_CYCLES=20, LOOP_LIMIT=3, `pc` incrementing by 4 every cycle. Pulse `start` → `cpu_reset` stays high 4 cycles, `cpu_en` high 20 cycles, then `done`=1, `done_cause`=1, `cycle_cnt`=20.
- Same parameters, `pc`=0x3000, 0x3004, 0x3008, 0x300c, then 0x300c constant → `done_cause`=2, `cycle_cnt`=7. `same_cnt` reaches 3 on RUN cycle index 6.
- `abort` high in RUN cycle 5 with `pc` equal for 3 samples on that same cycle → cause 3 (abort wins), `cycle_cnt`=6.
- `abort` during RESET → DONE, cause 3, `cycle_cnt`=0, `cpu_en` never asserted.
- `reset` low mid-RUN at cycle 10 → asynchronously IDLE: `cpu_reset`=1, `cpu_en`=0, `cycle_cnt`=0. Then `start` again → full 20-cycle run.
- From DONE, pulse `start` → counters clear, 4-cycle reset, new run. `start` pulses during RUN leave `cycle_cnt` unaffected.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for the mips core: sequences the core reset, gates its clock
// enable and ends a run on timeout, PC self-loop (halt) or external abort.
module cpu_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 2000,
    parameter int LOOP_LIMIT = 8,
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_cause,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SC_W = $clog2(LOOP_LIMIT + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_TIMEOUT = 2'd1,
        CAUSE_LOOP    = 2'd2,
        CAUSE_ABORT   = 2'd3
    } cause_t;

    state_t            state, state_nxt;
    cause_t            cause, cause_nxt;
    logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [SC_W-1:0]   same_cnt, same_cnt_nxt, same_inc;
    logic [CNT_W-1:0]  cyc, cyc_nxt, cyc_inc;
    logic [PC_W-1:0]   pc_prev, pc_prev_nxt;
    logic              pc_prev_vld, pc_prev_vld_nxt;

    // NOTE: every register uses <= so all state updates see the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cause       <= CAUSE_NONE;
            rst_cnt     <= '0;
            same_cnt    <= '0;
            cyc         <= '0;
            pc_prev     <= '0;
            pc_prev_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            cause       <= cause_nxt;
            rst_cnt     <= rst_cnt_nxt;
            same_cnt    <= same_cnt_nxt;
            cyc         <= cyc_nxt;
            pc_prev     <= pc_prev_nxt;
            pc_prev_vld <= pc_prev_vld_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        cause_nxt       = cause;
        rst_cnt_nxt     = rst_cnt;
        same_cnt_nxt    = same_cnt;
        cyc_nxt         = cyc;
        pc_prev_nxt     = pc_prev;
        pc_prev_vld_nxt = pc_prev_vld;

        // Both counters saturate rather than wrap, so a disabled limit never re-fires.
        cyc_inc  = (&cyc) ? cyc : cyc + 1'b1;
        if (pc_prev_vld && (pc == pc_prev))
            same_inc = (&same_cnt) ? same_cnt : same_cnt + 1'b1;
        else
            same_inc = '0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt       = S_RESET;
                    rst_cnt_nxt     = RC_W'(RST_CYCLES);
                    cyc_nxt         = '0;
                    cause_nxt       = CAUSE_NONE;
                    same_cnt_nxt    = '0;
                    pc_prev_vld_nxt = 1'b0;
                end
            end
            S_RESET: begin
                if (abort) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_ABORT;
                end else begin
                    rst_cnt_nxt = rst_cnt - 1'b1;
                    if (rst_cnt <= RC_W'(1))
                        state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                cyc_nxt         = cyc_inc;
                pc_prev_nxt     = pc;
                pc_prev_vld_nxt = 1'b1;
                same_cnt_nxt    = same_inc;
                if (abort) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_ABORT;
                end else if ((LOOP_LIMIT != 0) && (same_inc == SC_W'(LOOP_LIMIT))) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_LOOP;
                end else if ((MAX_CYCLES != 0) && (cyc_inc == CNT_W'(MAX_CYCLES))) begin
                    state_nxt = S_DONE;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore decode straight from the state register: no input reaches an output.
    always_comb begin
        cpu_reset = 1'b0;
        cpu_en    = 1'b0;
        running   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_RESET: cpu_reset = 1'b1;
            S_RUN: begin
                cpu_en  = 1'b1;
                running = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: cpu_reset = 1'b1;
        endcase
    end

    assign done_cause = cause;
    assign cycle_cnt  = cyc;

endmodule
